alu_cmd_sequencer: RTL and testbench

- Initiator side of the ALU operand/opcode interface.
- Accepts commands (A, B, SEL) on a valid/ready port and drives them onto the combinational N-bit ALU's A/B/SEL inputs as registered signals.
- Waits a programmable settle time, captures SUM/CarryOut, and returns a flagged response on a second valid/ready port.
- Traps division by zero without issuing the operation to the ALU.

---
 rtl/alu_cmd_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Initiator for a combinational N-bit ALU. Commands are issued on registered
// ALU inputs, sampled after a settle window and returned as a flagged response.
module alu_cmd_sequencer #(
  parameter int N             = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [N-1:0]     cmd_a,
  input  logic [N-1:0]     cmd_b,
  input  logic [3:0]       cmd_sel,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [3:0]       alu_sel,
  input  logic [N-1:0]     alu_sum,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0]       SEL_DIV     = 4'b0011;
  localparam int               SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0]    SETTLE_ZERO = SW'(0);
  localparam logic [SW-1:0]    SETTLE_ONE  = SW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_r;
  logic [SW-1:0] settle_r;
  logic          trap_r;

  function automatic logic is_div_zero(input logic [3:0] sel, input logic [N-1:0] b);
    return (sel == SEL_DIV) && (b == {N{1'b0}});
  endfunction

  // Command/response FSM; a trapped divide skips the settle window but still
  // spends one cycle in EXEC so its response timing matches a one-cycle settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      settle_r   <= SETTLE_ZERO;
      trap_r     <= 1'b0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      alu_a      <= {N{1'b0}};
      alu_b      <= {N{1'b0}};
      alu_sel    <= 4'b0000;
      rsp_result <= {N{1'b0}};
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      op_count   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            if (is_div_zero(cmd_sel, cmd_b)) begin
              trap_r   <= 1'b1;
              settle_r <= SETTLE_ZERO;
            end else begin
              trap_r   <= 1'b0;
              settle_r <= SETTLE_LOAD;
              alu_a    <= cmd_a;
              alu_b    <= cmd_b;
              alu_sel  <= cmd_sel;
            end
            state_r   <= EXEC;
            cmd_ready <= 1'b0;
          end
        end
        EXEC: begin
          if (settle_r == SETTLE_ZERO) begin
            if (trap_r) begin
              rsp_result <= {N{1'b1}};
              rsp_carry  <= 1'b0;
              rsp_zero   <= 1'b0;
              rsp_err    <= 1'b1;
            end else begin
              rsp_result <= alu_sum;
              rsp_carry  <= alu_carry;
              rsp_zero   <= (alu_sum == {N{1'b0}});
              rsp_err    <= 1'b0;
            end
            state_r   <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            settle_r <= settle_r - SETTLE_ONE;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            op_count  <= op_count + CNT_ONE;
            state_r   <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: two instances (settle 1 / 4-bit counter and
// settle 4 / 16-bit counter), each driving a behavioural ALU.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [7:0] cmd_a     [2];
  logic [7:0] cmd_b     [2];
  logic [3:0] cmd_sel   [2];
  logic [7:0] alu_a     [2];
  logic [7:0] alu_b     [2];
  logic [3:0] alu_sel   [2];
  logic [7:0] alu_sum   [2];
  logic       alu_carry [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [7:0] rsp_result[2];
  logic       rsp_carry [2];
  logic       rsp_zero  [2];
  logic       rsp_err   [2];
  logic [15:0] op_count [2];

  int checks = 0;
  int errors = 0;

  // Reference model state: last issued operands and completed-response count.
  logic [7:0] m_a  [2];
  logic [7:0] m_b  [2];
  logic [3:0] m_sel[2];
  int         m_cnt[2];

  // Results of one transaction as observed by run_cmd.
  int          r_lat, r_unstable;
  logic [7:0]  r_res, r_a, r_b;
  logic [3:0]  r_sel;
  logic        r_car, r_zer, r_err, r_rdy, r_kept;
  logic [15:0] r_cnt;

  always #5 clk = ~clk;

  // Behavioural ALU: {carry, result}. Sub carry is the borrow; mul carry flags
  // a nonzero upper byte; eq returns 1 when the operands match.
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    logic [15:0] p;
    case (sel)
      4'h0: return {1'b0, a} + {1'b0, b};
      4'h1: return {(a < b), 8'(a - b)};
      4'h2: begin p = a * b; return {(p[15:8] != 8'h00), p[7:0]}; end
      4'h3: return (b == 8'h00) ? 9'h0FF : {1'b0, 8'(a / b)};
      4'h4: return {1'b0, a & b};
      4'h5: return {1'b0, a | b};
      4'h6: return {1'b0, a ^ b};
      4'hF: return {1'b0, 7'd0, (a == b)};
      default: return {1'b0, a};
    endcase
  endfunction

  always_comb begin
    for (int j = 0; j < 2; j++) begin
      {alu_carry[j], alu_sum[j]} = alu_fn(alu_a[j], alu_b[j], alu_sel[j]);
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int ST = (g == 0) ? 1 : 4;
    localparam int CW = (g == 0) ? 4 : 16;
    logic [CW-1:0] oc;
    alu_cmd_sequencer #(.N(8), .SETTLE_CYCLES(ST), .CNT_W(CW)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
      .cmd_a(cmd_a[g]), .cmd_b(cmd_b[g]), .cmd_sel(cmd_sel[g]),
      .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_sel(alu_sel[g]),
      .alu_sum(alu_sum[g]), .alu_carry(alu_carry[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_result(rsp_result[g]), .rsp_carry(rsp_carry[g]),
      .rsp_zero(rsp_zero[g]), .rsp_err(rsp_err[g]),
      .op_count(oc)
    );
    assign op_count[g] = 16'(oc);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at time %0t, expected completion", $time);
    $fatal(1);
  end

  function automatic int cnt_mod(input int i, input int c);
    return (i == 0) ? (c % 16) : (c % 65536);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_a[i] = 8'h00; m_b[i] = 8'h00; m_sel[i] = 4'h0; m_cnt[i] = 0;
    end
  endtask

  task automatic note_cmd(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    if (!(sel == 4'h3 && b == 8'h00)) begin
      m_a[i] = a; m_b[i] = b; m_sel[i] = sel;
    end
    m_cnt[i] = m_cnt[i] + 1;
  endtask

  // Issues one command starting at a negedge in IDLE, holds the response for
  // 'hold' cycles while offering a competing command, then completes it.
  task automatic run_cmd(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                         input int hold,
                         output int lat, output logic [7:0] res, output logic car, output logic zer,
                         output logic er, output logic [7:0] oa, output logic [7:0] ob,
                         output logic [3:0] osel, output logic [15:0] cnt, output logic rdy_after,
                         output logic kept, output int unstable);
    cmd_a[i] = a; cmd_b[i] = b; cmd_sel[i] = sel; cmd_valid[i] = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid[i] = 1'b0;
    oa = alu_a[i]; ob = alu_b[i]; osel = alu_sel[i];
    lat = 0;
    while (rsp_valid[i] !== 1'b1 && lat < 40) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    res = rsp_result[i]; car = rsp_carry[i]; zer = rsp_zero[i]; er = rsp_err[i];
    unstable = 0;
    for (int h = 0; h < hold; h++) begin
      cmd_a[i] = ~a; cmd_b[i] = 8'h01; cmd_sel[i] = 4'h0; cmd_valid[i] = 1'b1;
      @(posedge clk); @(negedge clk);
      if (rsp_valid[i] !== 1'b1 || cmd_ready[i] !== 1'b0 || rsp_result[i] !== res ||
          rsp_carry[i] !== car || rsp_zero[i] !== zer || rsp_err[i] !== er ||
          alu_a[i] !== oa || alu_b[i] !== ob || alu_sel[i] !== osel)
        unstable++;
    end
    cmd_valid[i] = 1'b0;
    rsp_ready[i] = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready[i] = 1'b0;
    cnt = op_count[i];
    rdy_after = cmd_ready[i] && !rsp_valid[i];
    kept = (rsp_result[i] === res) && (rsp_carry[i] === car) && (rsp_zero[i] === zer) && (rsp_err[i] === er);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0; rsp_ready[i] = 1'b0;
      cmd_a[i] = 8'h00; cmd_b[i] = 8'h00; cmd_sel[i] = 4'h0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({cmd_ready[i], rsp_valid[i], rsp_carry[i], rsp_zero[i], rsp_err[i]} !== 5'b10000) begin
        errors++;
        $display("FAIL reset_flags[%0d]: got %b expected 10000", i,
                 {cmd_ready[i], rsp_valid[i], rsp_carry[i], rsp_zero[i], rsp_err[i]});
      end
      checks++;
      if ({alu_a[i], alu_b[i], alu_sel[i], rsp_result[i]} !== 28'h0) begin
        errors++;
        $display("FAIL reset_data[%0d]: got %h expected 0", i, {alu_a[i], alu_b[i], alu_sel[i], rsp_result[i]});
      end
      checks++;
      if (op_count[i] !== 16'h0) begin
        errors++;
        $display("FAIL reset_count[%0d]: got %0d expected 0", i, op_count[i]);
      end
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_add_overflow();
    run_cmd(0, 8'hF0, 8'h20, 4'h0, 0, r_lat, r_res, r_car, r_zer, r_err, r_a, r_b, r_sel, r_cnt, r_rdy, r_kept, r_unstable);
    note_cmd(0, 8'hF0, 8'h20, 4'h0);
    checks++;
    if ({r_a, r_b, r_sel} !== {8'hF0, 8'h20, 4'h0}) begin
      errors++; $display("FAIL add_alu_inputs: got %h expected f0200", {r_a, r_b, r_sel});
    end
    checks++;
    if (r_lat !== 1) begin errors++; $display("FAIL add_latency: got %0d expected 1", r_lat); end
    checks++;
    if ({r_res, r_car, r_zer, r_err} !== {8'h10, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL add_response: got %h expected %h", {r_res, r_car, r_zer, r_err}, {8'h10, 3'b100});
    end
    checks++;
    if (r_cnt !== 16'd1 || r_rdy !== 1'b1) begin
      errors++; $display("FAIL add_handshake: got count %0d ready %b expected 1 1", r_cnt, r_rdy);
    end
  endtask

  task automatic test_zero_compare();
    run_cmd(1, 8'h05, 8'h05, 4'h1, 0, r_lat, r_res, r_car, r_zer, r_err, r_a, r_b, r_sel, r_cnt, r_rdy, r_kept, r_unstable);
    note_cmd(1, 8'h05, 8'h05, 4'h1);
    checks++;
    if (r_lat !== 4) begin errors++; $display("FAIL sub_latency: got %0d expected 4", r_lat); end
    checks++;
    if ({r_res, r_car, r_zer, r_err} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sub_zero: got %h expected %h", {r_res, r_car, r_zer, r_err}, {8'h00, 3'b010});
    end
    run_cmd(1, 8'h5A, 8'h5A, 4'hF, 0, r_lat, r_res, r_car, r_zer, r_err, r_a, r_b, r_sel, r_cnt, r_rdy, r_kept, r_unstable);
    note_cmd(1, 8'h5A, 8'h5A, 4'hF);
    checks++;
    if ({r_res, r_car, r_zer, r_err} !== {8'h01, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL eq_result: got %h expected %h", {r_res, r_car, r_zer, r_err}, {8'h01, 3'b000});
    end
    checks++;
    if (r_cnt !== 16'd2) begin errors++; $display("FAIL zero_cmp_count: got %0d expected 2", r_cnt); end
  endtask

  task automatic test_div_zero();
    run_cmd(1, 8'h64, 8'h00, 4'h3, 0, r_lat, r_res, r_car, r_zer, r_err, r_a, r_b, r_sel, r_cnt, r_rdy, r_kept, r_unstable);
    note_cmd(1, 8'h64, 8'h00, 4'h3);
    checks++;
    if (r_lat !== 1) begin errors++; $display("FAIL div0_latency: got %0d expected 1", r_lat); end
    checks++;
    if ({r_res, r_car, r_zer, r_err} !== {8'hFF, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL div0_response: got %h expected %h", {r_res, r_car, r_zer, r_err}, {8'hFF, 3'b001});
    end
    checks++;
    if ({r_a, r_b, r_sel} !== {8'h5A, 8'h5A, 4'hF}) begin
      errors++; $display("FAIL div0_alu_held: got %h expected 5a5af", {r_a, r_b, r_sel});
    end
    checks++;
    if (r_cnt !== 16'd3) begin errors++; $display("FAIL div0_count: got %0d expected 3", r_cnt); end
  endtask

  task automatic test_backpressure();
    run_cmd(1, 8'h12, 8'h34, 4'h0, 5, r_lat, r_res, r_car, r_zer, r_err, r_a, r_b, r_sel, r_cnt, r_rdy, r_kept, r_unstable);
    note_cmd(1, 8'h12, 8'h34, 4'h0);
    checks++;
    if ({r_res, r_car, r_zer, r_err} !== {8'h46, 3'b000}) begin
      errors++; $display("FAIL bp_response: got %h expected %h", {r_res, r_car, r_zer, r_err}, {8'h46, 3'b000});
    end
    checks++;
    if (r_unstable !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", r_unstable); end
    checks++;
    if (r_rdy !== 1'b1 || r_kept !== 1'b1) begin
      errors++; $display("FAIL bp_release: got ready %b kept %b expected 1 1", r_rdy, r_kept);
    end
    checks++;
    if (r_cnt !== 16'd4) begin errors++; $display("FAIL bp_count: got %0d expected 4", r_cnt); end
  endtask

  task automatic test_random();
    logic [3:0] sels [8];
    logic [7:0] a, b, e_res;
    logic [3:0] sel;
    logic       e_car, e_zer, e_err, div0;
    int         i, hold, e_lat;
    sels = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hF};
    for (int n = 0; n < 24; n++) begin
      i    = int'($urandom_range(1, 0));
      a    = 8'($urandom);
      b    = ($urandom_range(3, 0) == 0) ? 8'h00 : 8'($urandom);
      sel  = sels[$urandom_range(7, 0)];
      hold = int'($urandom_range(3, 0));
      div0 = (sel == 4'h3) && (b == 8'h00);
      if (div0) begin
        e_res = 8'hFF; e_car = 1'b0; e_zer = 1'b0; e_err = 1'b1; e_lat = 1;
      end else begin
        {e_car, e_res} = alu_fn(a, b, sel);
        e_zer = (e_res == 8'h00); e_err = 1'b0; e_lat = (i == 0) ? 1 : 4;
      end
      note_cmd(i, a, b, sel);
      run_cmd(i, a, b, sel, hold, r_lat, r_res, r_car, r_zer, r_err, r_a, r_b, r_sel, r_cnt, r_rdy, r_kept, r_unstable);
      checks++;
      if (r_lat !== e_lat) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, r_lat, e_lat); end
      checks++;
      if ({r_res, r_car, r_zer, r_err} !== {e_res, e_car, e_zer, e_err}) begin
        errors++; $display("FAIL rnd%0d_response: sel %h a %h b %h got %h expected %h", n, sel, a, b,
                           {r_res, r_car, r_zer, r_err}, {e_res, e_car, e_zer, e_err});
      end
      checks++;
      if ({r_a, r_b, r_sel} !== {m_a[i], m_b[i], m_sel[i]}) begin
        errors++; $display("FAIL rnd%0d_alu: got %h expected %h", n, {r_a, r_b, r_sel}, {m_a[i], m_b[i], m_sel[i]});
      end
      checks++;
      if (r_cnt !== 16'(cnt_mod(i, m_cnt[i]))) begin
        errors++; $display("FAIL rnd%0d_count: got %0d expected %0d", n, r_cnt, cnt_mod(i, m_cnt[i]));
      end
      checks++;
      if (r_unstable !== 0 || r_rdy !== 1'b1 || r_kept !== 1'b1) begin
        errors++; $display("FAIL rnd%0d_handshake: got unstable %0d ready %b kept %b expected 0 1 1",
                           n, r_unstable, r_rdy, r_kept);
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    int viol;
    cmd_a[1] = 8'h11; cmd_b[1] = 8'h22; cmd_sel[1] = 4'h0; cmd_valid[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid[1] = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    checks++;
    if (rsp_valid[1] !== 1'b0 || cmd_ready[1] !== 1'b0 || alu_a[1] !== 8'h11) begin
      errors++; $display("FAIL mid_exec_state: got valid %b ready %b alu_a %h expected 0 0 11",
                         rsp_valid[1], cmd_ready[1], alu_a[1]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready[1], rsp_valid[1], rsp_carry[1], rsp_zero[1], rsp_err[1]} !== 5'b10000 ||
        {alu_a[1], alu_b[1], alu_sel[1], rsp_result[1]} !== 28'h0) begin
      errors++; $display("FAIL async_reset_outputs: got flags %b data %h expected 10000 0",
                         {cmd_ready[1], rsp_valid[1], rsp_carry[1], rsp_zero[1], rsp_err[1]},
                         {alu_a[1], alu_b[1], alu_sel[1], rsp_result[1]});
    end
    checks++;
    if (op_count[0] !== 16'h0 || op_count[1] !== 16'h0) begin
      errors++; $display("FAIL async_reset_count: got %0d %0d expected 0 0", op_count[0], op_count[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    viol = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[0] !== 1'b0 || rsp_valid[1] !== 1'b0 || cmd_ready[1] !== 1'b1) viol++;
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL post_reset_quiet: got %0d bad cycles expected 0", viol); end
  endtask

  task automatic test_counter_wrap();
    time t_start;
    t_start = $time;
    for (int k = 0; k < 17; k++) begin
      run_cmd(0, 8'h10, 8'h10, 4'h2, 0, r_lat, r_res, r_car, r_zer, r_err, r_a, r_b, r_sel, r_cnt, r_rdy, r_kept, r_unstable);
      note_cmd(0, 8'h10, 8'h10, 4'h2);
      checks++;
      if ({r_res, r_car, r_zer, r_err} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
        errors++; $display("FAIL wrap%0d_response: got %h expected %h", k, {r_res, r_car, r_zer, r_err}, {8'h00, 3'b110});
      end
      checks++;
      if (r_cnt !== 16'((k + 1) % 16)) begin
        errors++; $display("FAIL wrap%0d_count: got %0d expected %0d", k, r_cnt, (k + 1) % 16);
      end
    end
    checks++;
    if (($time - t_start) !== 64'd510) begin
      errors++; $display("FAIL wrap_throughput: got %0t time units for 17 ops expected 510", $time - t_start);
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_zero_compare();
    test_div_zero();
    test_backpressure();
    test_random();
    test_reset_mid_exec();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
